// File: rtl/rc4_crack_core.sv
// RC4 brute-force key search: for each key runs S-box init, key schedule and PRGA decrypt of a
// ciphertext ROM, stopping on the first key whose plaintext is all lowercase letters or spaces.
module rc4_crack_core #(
    parameter int unsigned                KEY_BYTES  = 3,
    parameter int unsigned                MSG_LEN    = 32,
    parameter logic [8*KEY_BYTES-1:0]     KEY_START  = '0,
    parameter logic [8*KEY_BYTES-1:0]     KEY_STRIDE = (8*KEY_BYTES)'(1),
    parameter logic [8*KEY_BYTES-1:0]     KEY_MAX    = (8*KEY_BYTES)'(32'h3FFFFF),
    localparam int unsigned               KW         = 8 * KEY_BYTES,
    localparam int unsigned               AW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [AW-1:0] rom_addr_o,
    output logic          rom_rden_o,
    input  logic [7:0]    rom_q_i,
    output logic [AW-1:0] res_addr_o,
    output logic [7:0]    res_data_o,
    output logic          res_wren_o,
    output logic [KW-1:0] cur_key_o,
    output logic [KW-1:0] found_key_o,
    output logic          busy_o,
    output logic          success_o,
    output logic          failure_o
);

    localparam logic [AW-1:0] KLast = AW'(MSG_LEN - 1);
    localparam int unsigned   NW    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [NW-1:0] NLast = NW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StShRd,
        StShJ,
        StShWrI,
        StShWrJ,
        StDcRd,
        StDcJ,
        StDcWrI,
        StDcWrJ,
        StDcT,
        StDcOut
    } state_e;

    state_e        state_q;
    logic [7:0]    i_q, j_q, si_q, sj_q;
    logic [NW-1:0] n_q;
    logic [AW-1:0] k_q;
    logic [KW-1:0] cur_key_q, found_key_q;
    logic          busy_q, success_q, failure_q;
    logic          rom_rden_q, res_wren_q;
    logic [AW-1:0] rom_addr_q, res_addr_q;
    logic [7:0]    res_data_q;

    logic [7:0]    sbox_q [256];
    logic [7:0]    sbox_rdata_q;
    logic          sbox_we;
    logic [7:0]    sbox_waddr, sbox_wdata, sbox_raddr;

    logic [7:0]    j_next, key_byte, plain;
    logic          plain_ok;
    logic [KW:0]   key_next;

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < int'(KEY_BYTES); b++) begin
            if (int'(n_q) == b) key_byte = cur_key_q[KW-1-8*b -: 8];
        end
        j_next = j_q + sbox_rdata_q;
        if (state_q == StShJ) j_next = j_next + key_byte;
        plain    = sbox_rdata_q ^ rom_q_i;
        plain_ok = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A));
        // Extra top bit catches KW-bit wrap-around of the next key.
        key_next = {1'b0, cur_key_q} + {1'b0, KEY_STRIDE};

        sbox_we    = 1'b0;
        sbox_waddr = i_q;
        sbox_wdata = i_q;
        sbox_raddr = i_q;
        case (state_q)
            StInit: sbox_we = 1'b1;
            StShJ, StDcJ: sbox_raddr = j_next;
            StShWrI, StDcWrI: begin
                sbox_we    = 1'b1;
                sbox_wdata = sbox_rdata_q;
            end
            StShWrJ, StDcWrJ: begin
                sbox_we    = 1'b1;
                sbox_waddr = j_q;
                sbox_wdata = si_q;
            end
            // Read S[t] only after both swap writes have landed.
            StDcT: sbox_raddr = si_q + sj_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sbox_we) sbox_q[sbox_waddr] <= sbox_wdata;
        sbox_rdata_q <= sbox_q[sbox_raddr];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            n_q         <= '0;
            k_q         <= '0;
            cur_key_q   <= KEY_START;
            found_key_q <= '0;
            busy_q      <= 1'b0;
            success_q   <= 1'b0;
            failure_q   <= 1'b0;
            rom_rden_q  <= 1'b0;
            rom_addr_q  <= '0;
            res_wren_q  <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else begin
            rom_rden_q <= 1'b0;
            res_wren_q <= 1'b0;
            if (busy_q && stop_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i && !stop_i) begin
                            success_q   <= 1'b0;
                            failure_q   <= 1'b0;
                            found_key_q <= '0;
                            cur_key_q   <= KEY_START;
                            busy_q      <= 1'b1;
                            i_q         <= '0;
                            state_q     <= StInit;
                        end
                    end
                    StInit: begin
                        i_q <= i_q + 8'd1;
                        if (i_q == 8'hFF) begin
                            j_q     <= '0;
                            n_q     <= '0;
                            state_q <= StShRd;
                        end
                    end
                    StShRd: state_q <= StShJ;
                    StShJ: begin
                        si_q    <= sbox_rdata_q;
                        j_q     <= j_next;
                        state_q <= StShWrI;
                    end
                    StShWrI: begin
                        sj_q    <= sbox_rdata_q;
                        state_q <= StShWrJ;
                    end
                    StShWrJ: begin
                        n_q <= (n_q == NLast) ? '0 : n_q + 1'b1;
                        if (i_q == 8'hFF) begin
                            i_q     <= 8'd1;
                            j_q     <= '0;
                            k_q     <= '0;
                            state_q <= StDcRd;
                        end else begin
                            i_q     <= i_q + 8'd1;
                            state_q <= StShRd;
                        end
                    end
                    StDcRd: state_q <= StDcJ;
                    StDcJ: begin
                        si_q    <= sbox_rdata_q;
                        j_q     <= j_next;
                        state_q <= StDcWrI;
                    end
                    StDcWrI: begin
                        sj_q    <= sbox_rdata_q;
                        state_q <= StDcWrJ;
                    end
                    StDcWrJ: begin
                        rom_rden_q <= 1'b1;
                        rom_addr_q <= k_q;
                        state_q    <= StDcT;
                    end
                    StDcT: state_q <= StDcOut;
                    StDcOut: begin
                        res_wren_q <= 1'b1;
                        res_addr_q <= k_q;
                        res_data_q <= plain;
                        if (!plain_ok) begin
                            if (key_next[KW] || (key_next[KW-1:0] > KEY_MAX)) begin
                                failure_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= StIdle;
                            end else begin
                                cur_key_q <= key_next[KW-1:0];
                                i_q       <= '0;
                                state_q   <= StInit;
                            end
                        end else if (k_q == KLast) begin
                            found_key_q <= cur_key_q;
                            success_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            i_q     <= i_q + 8'd1;
                            k_q     <= k_q + 1'b1;
                            state_q <= StDcRd;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign rom_rden_o  = rom_rden_q;
    assign res_addr_o  = res_addr_q;
    assign res_data_o  = res_data_q;
    assign res_wren_o  = res_wren_q;
    assign cur_key_o   = cur_key_q;
    assign found_key_o = found_key_q;
    assign busy_o      = busy_q;
    assign success_o   = success_q;
    assign failure_o   = failure_q;

endmodule

// File: tb/tb_rc4_crack_core.sv
// Directed bench for rc4_crack_core: three instances cover search success, key-space
// exhaustion, strided keys, stop abort and asynchronous reset.
module tb_rc4_crack_core;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [7:0] rom [8];

    logic        a_start, a_stop, a_rom_rden, a_res_wren, a_busy, a_success, a_failure;
    logic [2:0]  a_rom_addr, a_res_addr;
    logic [7:0]  a_rom_q, a_res_data;
    logic [31:0] a_cur_key, a_found_key;

    logic        b_start, b_stop, b_rom_rden, b_res_wren, b_busy, b_success, b_failure;
    logic [2:0]  b_rom_addr, b_res_addr;
    logic [7:0]  b_rom_q, b_res_data;
    logic [31:0] b_cur_key, b_found_key;

    logic        c_start, c_stop, c_rom_rden, c_res_wren, c_busy, c_success, c_failure;
    logic [2:0]  c_rom_addr, c_res_addr;
    logic [7:0]  c_rom_q, c_res_data;
    logic [31:0] c_cur_key, c_found_key;

    rc4_crack_core #(
        .KEY_BYTES(4), .MSG_LEN(5), .KEY_START(32'h57696B67), .KEY_STRIDE(32'd1),
        .KEY_MAX(32'hFFFFFFFF)
    ) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .start_i(a_start), .stop_i(a_stop),
        .rom_addr_o(a_rom_addr), .rom_rden_o(a_rom_rden), .rom_q_i(a_rom_q),
        .res_addr_o(a_res_addr), .res_data_o(a_res_data), .res_wren_o(a_res_wren),
        .cur_key_o(a_cur_key), .found_key_o(a_found_key), .busy_o(a_busy),
        .success_o(a_success), .failure_o(a_failure)
    );

    rc4_crack_core #(
        .KEY_BYTES(4), .MSG_LEN(5), .KEY_START(32'h57696B6A), .KEY_STRIDE(32'd1),
        .KEY_MAX(32'h57696B6A)
    ) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .start_i(b_start), .stop_i(b_stop),
        .rom_addr_o(b_rom_addr), .rom_rden_o(b_rom_rden), .rom_q_i(b_rom_q),
        .res_addr_o(b_res_addr), .res_data_o(b_res_data), .res_wren_o(b_res_wren),
        .cur_key_o(b_cur_key), .found_key_o(b_found_key), .busy_o(b_busy),
        .success_o(b_success), .failure_o(b_failure)
    );

    rc4_crack_core #(
        .KEY_BYTES(4), .MSG_LEN(5), .KEY_START(32'h57696B68), .KEY_STRIDE(32'd2),
        .KEY_MAX(32'hFFFFFFFF)
    ) dut_c (
        .clk_i(clk), .reset_ni(reset_n), .start_i(c_start), .stop_i(c_stop),
        .rom_addr_o(c_rom_addr), .rom_rden_o(c_rom_rden), .rom_q_i(c_rom_q),
        .res_addr_o(c_res_addr), .res_data_o(c_res_data), .res_wren_o(c_res_wren),
        .cur_key_o(c_cur_key), .found_key_o(c_found_key), .busy_o(c_busy),
        .success_o(c_success), .failure_o(c_failure)
    );

    // Ciphertext ROMs (one read port per instance) and result RAM capture for dut_a.
    always @(posedge clk) begin
        if (a_rom_rden) a_rom_q <= rom[a_rom_addr];
        if (b_rom_rden) b_rom_q <= rom[b_rom_addr];
        if (c_rom_rden) c_rom_q <= rom[c_rom_addr];
    end

    logic [7:0] res_ram [8];
    logic       res_clr = 1'b0;
    int         wren_cnt = 0;
    always @(posedge clk) begin
        if (res_clr) begin
            for (int k = 0; k < 8; k++) res_ram[k] <= 8'h00;
        end else if (a_res_wren) begin
            res_ram[a_res_addr] <= a_res_data;
            wren_cnt <= wren_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_q [$];
    logic [31:0] key_q [$];
    logic [15:0] ent;
    logic [31:0] prev_key;
    logic [7:0]  pedia [5];
    int          we_cnt, sbox_bad, snap;

    initial begin
        rom[0] = 8'h10; rom[1] = 8'h21; rom[2] = 8'hBF; rom[3] = 8'h04; rom[4] = 8'h20;
        rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h00;
        pedia[0] = 8'h70; pedia[1] = 8'h65; pedia[2] = 8'h64; pedia[3] = 8'h69; pedia[4] = 8'h61;
        reset_n = 1'b0;
        a_start = 1'b0; a_stop = 1'b0;
        b_start = 1'b0; b_stop = 1'b0;
        c_start = 1'b0; c_stop = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_busy", a_busy, 0);
        check("rst_success", a_success, 0);
        check("rst_failure", a_failure, 0);
        check("rst_rden", a_rom_rden, 0);
        check("rst_wren", a_res_wren, 0);
        check("rst_found", a_found_key, 0);
        check("rst_cur_a", a_cur_key, 32'h57696B67);
        check("rst_cur_c", c_cur_key, 32'h57696B68);

        // Search from ...67 must land on "Wiki" and decrypt "pedia"; probe INIT on the way.
        for (int k = 0; k < 5; k++) exp_q.push_back({5'(k), 3'(k), pedia[k]});
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("start_busy", a_busy, 1);
        we_cnt = 0;
        for (int c = 0; c < 256; c++) begin
            if (dut_a.sbox_we) we_cnt++;
            @(negedge clk);
        end
        check("init_writes", we_cnt, 256);
        check("init_done_no_we", dut_a.sbox_we, 0);
        sbox_bad = 0;
        for (int k = 0; k < 256; k++) if (dut_a.sbox_q[k] !== 8'(k)) sbox_bad++;
        check("init_identity", sbox_bad, 0);

        for (int c = 0; c < 10000 && !a_success && !a_failure; c++) @(negedge clk);
        check("t1_success", a_success, 1);
        check("t1_failure", a_failure, 0);
        check("t1_busy", a_busy, 0);
        check("t1_found", a_found_key, 32'h57696B69);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            check("t1_result", res_ram[ent[10:8]], ent[7:0]);
        end

        // Single-key space with a wrong key -> failure.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 3000 && !b_failure && !b_success; c++) @(negedge clk);
        check("t2_failure", b_failure, 1);
        check("t2_success", b_success, 0);
        check("t2_busy", b_busy, 0);

        // Stride 2 walks ...68, ...6A, ...6C.
        key_q.push_back(32'h57696B68);
        key_q.push_back(32'h57696B6A);
        key_q.push_back(32'h57696B6C);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        check("t5_key0", c_cur_key, key_q.pop_front());
        for (int n = 0; n < 2; n++) begin
            prev_key = c_cur_key;
            for (int c = 0; c < 3000 && c_cur_key === prev_key; c++) @(negedge clk);
            check("t5_key_next", c_cur_key, key_q.pop_front());
        end
        c_stop = 1'b1;
        @(negedge clk);
        c_stop = 1'b0;
        check("t5_stop_busy", c_busy, 0);

        // Stop during the second key's shuffle, then a clean restart.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("t4_restart_clears", a_success, 0);
        for (int c = 0; c < 3000 && a_cur_key !== 32'h57696B68; c++) @(negedge clk);
        check("t4_second_key", a_cur_key, 32'h57696B68);
        repeat (400) @(negedge clk);
        a_stop = 1'b1;
        @(negedge clk);
        a_stop = 1'b0;
        snap = wren_cnt;
        check("t4_stop_busy", a_busy, 0);
        check("t4_stop_success", a_success, 0);
        check("t4_stop_failure", a_failure, 0);
        check("t4_stop_key_hold", a_cur_key, 32'h57696B68);
        repeat (50) @(negedge clk);
        check("t4_no_wren", wren_cnt, snap);
        check("t4_idle", a_busy, 0);

        res_clr = 1'b1;
        @(negedge clk);
        res_clr = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back({5'(k), 3'(k), pedia[k]});
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 10000 && !a_success && !a_failure; c++) @(negedge clk);
        check("t4_re_success", a_success, 1);
        check("t4_re_found", a_found_key, 32'h57696B69);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            check("t4_result", res_ram[ent[10:8]], ent[7:0]);
        end

        // Asynchronous reset in the middle of the second key's decrypt phase.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 3000 && a_cur_key !== 32'h57696B68; c++) @(negedge clk);
        for (int c = 0; c < 3000 && !a_rom_rden; c++) @(negedge clk);
        check("t6_in_dec", a_rom_rden, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy", a_busy, 0);
        check("t6_rden", a_rom_rden, 0);
        check("t6_wren", a_res_wren, 0);
        check("t6_success", a_success, 0);
        check("t6_failure", a_failure, 0);
        check("t6_found", a_found_key, 0);
        check("t6_cur_key", a_cur_key, 32'h57696B67);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
